// File: rtl/reg_mask_encoder.sv
// Sequential 32:5 register-mask encoder: drains a register-select mask into
// lowest-first 5-bit indices. Optional macro REG_MASK_ENCODER_SKIP_XZR_EN drops register 31.
module reg_mask_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_valid,
  input  logic [31:0] load_mask,
  output logic        load_ready,
  input  logic        abort,
  output logic        idx_valid,
  input  logic        idx_ready,
  output logic [4:0]  idx,
  output logic        idx_last,
  output logic [5:0]  count,
  output logic        done
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t      state;
  logic [31:0] pending;
  logic [31:0] eff_mask;
  logic [4:0]  low_idx;
  logic [5:0]  pop;

`ifdef REG_MASK_ENCODER_SKIP_XZR_EN
  assign eff_mask = load_mask & 32'h7FFF_FFFF;
`else
  assign eff_mask = load_mask;
`endif

  always_comb begin
    low_idx = '0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (pending[i-1]) low_idx = 5'(i - 1);
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      pop = pop + 6'(pending[i]);
    end
  end

  // Outputs derive only from registered state; idle keeps pending at zero.
  assign load_ready = (state == IDLE);
  assign idx_valid  = (state == DRAIN);
  assign idx        = idx_valid ? low_idx : '0;
  assign idx_last   = idx_valid && (pop == 6'd1);
  assign count      = pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        pending <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (load_valid) begin
              pending <= eff_mask;
              if (eff_mask != '0) state <= DRAIN;
              else                done  <= 1'b1;
            end
          end
          DRAIN: begin
            if (idx_ready) begin
              // Clearing the lowest set bit is the same as clearing bit idx.
              pending <= pending & (pending - 32'd1);
              if (pop == 6'd1) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Self-checking bench for reg_mask_encoder: queue-based reference model plus
// directed vectors with literal expectations.
module tb_reg_mask_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_mask = '0;
  logic        load_ready;
  logic        abort = 1'b0;
  logic        idx_valid;
  logic        idx_ready = 1'b0;
  logic [4:0]  idx;
  logic        idx_last;
  logic [5:0]  count;
  logic        done;

  int n_chk = 0;
  int n_fail = 0;

`ifdef REG_MASK_ENCODER_SKIP_XZR_EN
  localparam logic [31:0] KEEP = 32'h7FFF_FFFF;
  localparam int          NFULL = 31;
`else
  localparam logic [31:0] KEEP = 32'hFFFF_FFFF;
  localparam int          NFULL = 32;
`endif

  reg_mask_encoder dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_mask(load_mask),
    .load_ready(load_ready), .abort(abort), .idx_valid(idx_valid),
    .idx_ready(idx_ready), .idx(idx), .idx_last(idx_last), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the pending registers as an ordered list of indices.
  int q[$];
  logic done_m = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      done_m = 1'b0;
    end else begin
      done_m = 1'b0;
      if (abort) begin
        q.delete();
      end else if (q.size() == 0) begin
        if (load_valid) begin
          for (int i = 0; i < 32; i++)
            if (load_mask[i] && KEEP[i]) q.push_back(i);
          if (q.size() == 0) done_m = 1'b1;
        end
      end else if (idx_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) done_m = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_valid",      32'(idx_valid),  32'(q.size() > 0));
    chk("m_load_ready", 32'(load_ready), 32'(q.size() == 0));
    chk("m_idx",        32'(idx),        (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("m_last",       32'(idx_last),   32'(q.size() == 1));
    chk("m_count",      32'(count),      32'(q.size()));
    chk("m_done",       32'(done),       32'(done_m));
  end

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic load(input logic [31:0] m);
    load_valid = 1'b1;
    load_mask  = m;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_load_ready", 32'(load_ready), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic drain
    idx_ready = 1'b1;
    load(32'h8000_0005);
    chk("basic_idx0", 32'(idx), 32'd0);
    chk("basic_last0", 32'(idx_last), 32'd0);
    @(negedge clk);
    chk("basic_idx2", 32'(idx), 32'd2);
`ifdef REG_MASK_ENCODER_SKIP_XZR_EN
    chk("basic_last2", 32'(idx_last), 32'd1);
`else
    chk("basic_last2", 32'(idx_last), 32'd0);
    @(negedge clk);
    chk("basic_idx31", 32'(idx), 32'd31);
    chk("basic_last31", 32'(idx_last), 32'd1);
`endif
    @(negedge clk);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_valid_off", 32'(idx_valid), 32'd0);
    @(negedge clk);
    chk("basic_done_drop", 32'(done), 32'd0);

    // Backpressure
    idx_ready = 1'b0;
    load(32'h0000_0300);
    for (int i = 0; i < 5; i++) begin
      chk("bp_idx", 32'(idx), 32'd8);
      chk("bp_count", 32'(count), 32'd2);
      @(negedge clk);
    end
    idx_ready = 1'b1;
    chk("bp_rel_idx8", 32'(idx), 32'd8);
    @(negedge clk);
    chk("bp_rel_idx9", 32'(idx), 32'd9);
    chk("bp_rel_last9", 32'(idx_last), 32'd1);
    @(negedge clk);
    chk("bp_done", 32'(done), 32'd1);

    // Empty mask
    load(32'h0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_valid", 32'(idx_valid), 32'd0);
    @(negedge clk);
    chk("empty_done_drop", 32'(done), 32'd0);

    // Bit 31 only: empty when register 31 is skipped
    load(32'h8000_0000);
    chk("b31_valid", 32'(idx_valid), 32'(NFULL == 32));
    @(negedge clk);
    @(negedge clk);

    // Full mask
    load(32'hFFFF_FFFF);
    for (int i = 0; i < NFULL; i++) begin
      chk("full_idx", 32'(idx), 32'(i));
      chk("full_count", 32'(count), 32'(NFULL - i));
      @(negedge clk);
    end
    chk("full_done", 32'(done), 32'd1);
    @(negedge clk);

    // Abort mid-drain, together with a handshake
    load(32'h0000_00F0);
    chk("abort_idx4", 32'(idx), 32'd4);
    @(negedge clk);
    chk("abort_idx5", 32'(idx), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 32'(idx_valid), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_load_ready", 32'(load_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);

    // Load ignored while busy
    idx_ready = 1'b0;
    load(32'h0000_0030);
    load_valid = 1'b1;
    load_mask  = 32'hFFFF_0000;
    chk("busy_load_ready", 32'(load_ready), 32'd0);
    @(negedge clk);
    load_valid = 1'b0;
    chk("busy_idx", 32'(idx), 32'd4);
    chk("busy_count", 32'(count), 32'd2);
    idx_ready = 1'b1;
    @(negedge clk);
    chk("busy_idx5", 32'(idx), 32'd5);
    @(negedge clk);
    chk("busy_done", 32'(done), 32'd1);
    chk("busy_idle", 32'(idx_valid), 32'd0);
    @(negedge clk);

    // Reset mid-drain, checked before any clock edge
    load(32'h0000_00F0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_idx6", 32'(idx), 32'd6);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(idx_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_idx", 32'(idx), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_after_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
